// File: rtl/spi_shift_sequencer_if.sv
// Host-side byte handshake bundle for spi_shift_sequencer.
// master drives the TX byte; slave returns ready and the RX byte.
interface spi_shift_sequencer_if;
  logic       i_tx_valid;
  logic [7:0] i_tx_data;
  logic       o_tx_ready;
  logic       o_rx_valid;
  logic [7:0] o_rx_data;

  modport master (
    output i_tx_valid,
    output i_tx_data,
    input  o_tx_ready,
    input  o_rx_valid,
    input  o_rx_data
  );

  modport slave (
    input  i_tx_valid,
    input  i_tx_data,
    output o_tx_ready,
    output o_rx_valid,
    output o_rx_data
  );
endinterface

// File: rtl/spi_shift_sequencer.sv
// Mode-0 SPI byte sequencer driving an external universal shift register.
// Define SPI_LSB_FIRST_EN for LSB-first transfers (right shift).
module spi_shift_sequencer #(
  parameter int CLK_DIV = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  spi_shift_sequencer_if.slave        host,
  output logic                        o_sr_s0,
  output logic                        o_sr_s1,
  output logic [7:0]                  o_sr_parallel,
  output logic                        o_sr_serial,
  input  logic [7:0]                  i_sr_parallel,
  output logic                        o_sclk,
  output logic                        o_cs_n,
  output logic                        o_mosi,
  input  logic                        i_miso
);

  generate
    if (CLK_DIV < 1) begin : g_bad_div
      $error("CLK_DIV must be >= 1");
    end
  endgenerate

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

`ifdef SPI_LSB_FIRST_EN
  localparam logic [1:0] SHIFT = 2'b10;
`else
  localparam logic [1:0] SHIFT = 2'b01;
`endif

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETUP,
    HIGH,
    LOW,
    ENDS
  } state_e;

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [1:0]  sr_s_q, sr_s_d;
  logic [7:0]  par_q, par_d;
  logic        serial_q, serial_d;
  logic        sclk_q, sclk_d;
  logic        cs_n_q, cs_n_d;
  logic        ready_q, ready_d;
  logic        rx_valid_q, rx_valid_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic [7:0]  sr_next;
  logic        last;

  // Value the shift register holds after this cycle's edge.
  always_comb begin
    sr_next = i_sr_parallel;
    if (sr_s_q == SHIFT) begin
`ifdef SPI_LSB_FIRST_EN
      sr_next = {serial_q, i_sr_parallel[7:1]};
`else
      sr_next = {i_sr_parallel[6:0], serial_q};
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    par_d      = par_q;
    serial_d   = serial_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    last       = (cnt_q == CNT_LAST);

    unique case (state_q)
      IDLE: begin
        if (host.i_tx_valid) begin
          par_d   = host.i_tx_data;
          state_d = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = SETUP;
      end
      SETUP: begin
        if (last) begin
          cnt_d   = '0;
          state_d = HIGH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HIGH: begin
        if (last) begin
          cnt_d   = '0;
          bit_d   = bit_q + 3'd1;
          state_d = (bit_q == 3'd7) ? ENDS : LOW;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      LOW: begin
        if (last) begin
          cnt_d   = '0;
          state_d = HIGH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ENDS: begin
        if (last) begin
          cnt_d      = '0;
          rx_data_d  = sr_next;
          rx_valid_d = 1'b1;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == HIGH && state_q != HIGH) begin
      serial_d = i_miso;
    end

    sclk_d  = (state_d == HIGH);
    cs_n_d  = (state_d == IDLE);
    ready_d = (state_d == IDLE);

    sr_s_d = 2'b00;
    if (state_d == LOAD) begin
      sr_s_d = 2'b11;
    end else if (state_q == HIGH && state_d != HIGH) begin
      sr_s_d = SHIFT;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      sr_s_q     <= 2'b00;
      par_q      <= '0;
      serial_q   <= 1'b0;
      sclk_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      ready_q    <= 1'b1;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      sr_s_q     <= sr_s_d;
      par_q      <= par_d;
      serial_q   <= serial_d;
      sclk_q     <= sclk_d;
      cs_n_q     <= cs_n_d;
      ready_q    <= ready_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
    end
  end

  assign o_sr_s0       = sr_s_q[1];
  assign o_sr_s1       = sr_s_q[0];
  assign o_sr_parallel = par_q;
  assign o_sr_serial   = serial_q;
  assign o_sclk        = sclk_q;
  assign o_cs_n        = cs_n_q;

`ifdef SPI_LSB_FIRST_EN
  assign o_mosi = !cs_n_q && i_sr_parallel[0];
`else
  assign o_mosi = !cs_n_q && i_sr_parallel[7];
`endif

  assign host.o_tx_ready = ready_q;
  assign host.o_rx_valid = rx_valid_q;
  assign host.o_rx_data  = rx_data_q;

endmodule

// File: doc/spi_shift_sequencer.md
# spi_shift_sequencer

Mode-0 SPI byte-transfer sequencer for the 8-bit universal shift register. It accepts a byte on a valid/ready handshake and parallel-loads it into the shift register. It then generates CS_n and SCLK, samples MISO, and issues one shift per SCLK falling edge. After eight bits it returns the received byte. It sits between the host-side command logic and the shift register, and is the only block that drives the shift register's S0/S1 controls.

## Interface
- CLK_DIV, 4, SCLK half-period in i_clk cycles; must be ≥1; elaboration error otherwise.
- i_clk  in  1  system clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_tx_valid  in  1  host byte available
- i_tx_data  in  8  byte to transmit
- o_tx_ready  out  1  high only in IDLE
- o_rx_valid  out  1  one-cycle pulse, received byte valid
- o_rx_data  out  8  received byte, held until next o_rx_valid
- o_sr_s0, o_sr_s1  out  1 each  shift register mode: 11 load, 01 left, 10 right, 00 hold
- o_sr_parallel  out  8  shift register parallel load data
- o_sr_serial  out  1  shift register serial input (registered MISO sample)
- i_sr_parallel  in  8  shift register contents
- o_sclk  out  1  SPI clock, idle low
- o_cs_n  out  1  chip select, active-low
- o_mosi  out  1  SPI data out
- i_miso  in  1  SPI data in

## Operation
- All outputs are registered except o_mosi.
- Reset values: o_tx_ready=1, o_rx_valid=0, o_rx_data=0, S0/S1=00, o_sr_parallel=0, o_sr_serial=0, o_sclk=0, o_cs_n=1. The 3-bit bit counter and the CLK_DIV counter both clear.
- o_mosi = i_sr_parallel[7] while o_cs_n=0, else 0.
- FSM states: IDLE, LOAD, SETUP, HIGH, LOW, END.
- IDLE: o_tx_ready=1 and S0/S1=00.
  - If i_tx_valid: capture i_tx_data into o_sr_parallel and go to LOAD.
- LOAD (1 cycle): S0/S1=11, o_cs_n=0, then SETUP.
- SETUP (CLK_DIV cycles): SCLK low, MOSI shows the MSB. Then HIGH.
- HIGH (CLK_DIV cycles): o_sclk=1.
  - On the entry edge, register i_miso into o_sr_serial.
  - On exit, if bit counter=7, go to END; else go to LOW.
  - Either exit issues one cycle of S0/S1=01 (shift) and increments the bit counter.
- LOW (CLK_DIV cycles): o_sclk=0, then HIGH.
- END (CLK_DIV cycles): o_sclk=0, o_cs_n=0 (CS hold). On exit:
  - latch i_sr_parallel into o_rx_data;
  - pulse o_rx_valid;
  - set o_cs_n=1;
  - return to IDLE.
- S0/S1 is 00 in every cycle not listed above.
- i_tx_valid outside IDLE is ignored; no queuing.
- Reset mid-transfer aborts immediately to reset values, with no o_rx_valid. The shift register shares i_rst_n and clears as well.
- The bit counter wraps 7→0 on the eighth shift.

## Timing
- Accept at cycle 0 (i_tx_valid & o_tx_ready) → o_rx_valid and o_tx_ready=1 at cycle 2+17·CLK_DIV.
- o_cs_n is low for exactly 1+17·CLK_DIV cycles.
- Exactly 8 SCLK high pulses per transfer, each CLK_DIV cycles wide.
- A shift occurs in the cycle SCLK falls. MOSI changes only after a falling edge and is stable across each rising edge (mode 0).
- MISO is sampled on the cycle SCLK rises.
- Back-to-back: a new byte may be accepted in the same cycle as o_rx_valid.

## Configuration
- SPI_LSB_FIRST_EN defined:
  - shift code is 10 (right shift);
  - o_mosi = i_sr_parallel[0];
  - the first bit received lands in bit 0 of o_rx_data.
- SPI_LSB_FIRST_EN undefined: MSB first, shift code 01, o_mosi from bit 7.

## Test plan
- CLK_DIV=2, MISO looped to MOSI, send 0xA5:
  - o_rx_data=0xA5 with o_rx_valid at cycle 36;
  - o_cs_n low for 35 cycles;
  - 8 SCLK pulses.
- i_miso held 1, send 0x00 → o_rx_data=0xFF. MOSI is 0 on all 8 rising edges.
- i_tx_valid held high during a transfer → o_tx_ready=0, no second LOAD, single o_rx_valid.
- Two bytes 0x3C, 0xC3 presented back-to-back → second accepted the cycle o_rx_valid rises; both received correctly in loopback.
- i_rst_n low after the 4th SCLK pulse → immediate o_cs_n=1, o_sclk=0, S0/S1=00, no o_rx_valid. A following transfer of 0x5A completes correctly.
- With SPI_LSB_FIRST_EN, send 0x01 in loopback → MOSI high only on first rising edge; o_rx_data=0x01.
